// File: rtl/cdc_clear_sequencer.sv
// Flush sequencer in front of a clearable CDC FIFO source port.
// Optional macro CDC_CLEAR_SEQ_DISCARD_EN: keep upstream ready and discard beats while busy.
module cdc_clear_sequencer #(
    parameter int  WIDTH          = 8,
    parameter type T              = logic [WIDTH-1:0],
    parameter int  TIMEOUT_CYCLES = 256,
    parameter int  DROP_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_req_i,
    output logic                      flush_busy_o,
    output logic                      flush_done_o,
    output logic                      flush_timeout_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_count_o,
    input  T                          in_data_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic                      fifo_clear_o,
    input  logic                      fifo_clear_pending_i,
    output T                          fifo_data_o,
    output logic                      fifo_valid_o,
    input  logic                      fifo_ready_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_CLEAR,
        S_WAIT_RISE,
        S_WAIT_FALL
    } state_e;

    state_e                    state_q, state_d;
    logic                      valid_q, valid_d;
    T                          data_q, data_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic                      timeout_q, timeout_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic [1:0]                drop_inc;
    logic [DROP_CNT_WIDTH:0]   drop_sum;
    logic                      pass_ok;

    assign pass_ok = !valid_q | fifo_ready_i;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        drop_inc     = 2'd0;
        in_ready_o   = 1'b0;
        fifo_valid_o = 1'b0;
        fifo_clear_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready_o   = pass_ok;
                fifo_valid_o = valid_q;
                if (pass_ok) begin
                    valid_d = in_valid_i;
                    if (in_valid_i) data_d = in_data_i;
                end
                if (flush_req_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                fifo_valid_o = valid_q;
                if (valid_q && !fifo_ready_i) drop_inc = 2'd1;
                valid_d = 1'b0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                fifo_clear_o = 1'b1;
                cnt_d        = '0;
                state_d      = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                cnt_d = cnt_q + CW'(1);
                // a normal exit takes priority over an expiring timeout
                if (fifo_clear_pending_i) begin
                    state_d = S_WAIT_FALL;
                end else if (cnt_q >= TMO_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            S_WAIT_FALL: begin
                cnt_d = cnt_q + CW'(1);
                if (!fifo_clear_pending_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q >= TMO_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CDC_CLEAR_SEQ_DISCARD_EN
        if (state_q != S_IDLE) begin
            in_ready_o = 1'b1;
            if (in_valid_i) drop_inc = drop_inc + 2'd1;
        end
`endif

        drop_sum = {1'b0, drop_q} + (DROP_CNT_WIDTH + 1)'(drop_inc);
        drop_d   = drop_sum[DROP_CNT_WIDTH] ? DROP_MAX
                                            : drop_sum[DROP_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
        end
    end

    assign fifo_data_o     = data_q;
    assign flush_busy_o    = (state_q != S_IDLE);
    assign flush_done_o    = done_q;
    assign flush_timeout_o = timeout_q;
    assign drop_count_o    = drop_q;

endmodule

// File: doc/cdc_clear_sequencer.md
# cdc_clear_sequencer

Source-side companion to the clearable gray-code CDC FIFO. It sits directly upstream of the FIFO's source port and forwards a valid/ready stream through a one-entry pipeline register. On a flush request it isolates the upstream stream and pulses the FIFO's synchronous clear. It then tracks the FIFO's clear-pending handshake to completion, with a timeout, and reports done, timeout and discarded-beat statistics.

## Interface

**Parameters**
- `WIDTH`, default 8: payload width.
- `T`, default `logic [WIDTH-1:0]`: payload type.
- `TIMEOUT_CYCLES`, default 256: maximum cycles spent in WAIT_RISE plus WAIT_FALL. Must be ≥ 2.
- `DROP_CNT_WIDTH`, default 16: width of the discarded-beat counter.

**Ports** (one clock, `clk_i`; reset `rst_i` is synchronous and active-high)
- `clk_i` in, 1: clock (FIFO source clock).
- `rst_i` in, 1: synchronous active-high reset.
- `flush_req_i` in, 1: start a flush sequence. Sampled only in IDLE.
- `flush_busy_o` out, 1: high while state ≠ IDLE.
- `flush_done_o` out, 1: one-cycle pulse; the sequence completed normally.
- `flush_timeout_o` out, 1: one-cycle pulse; the sequence aborted on timeout.
- `drop_count_o` out, `DROP_CNT_WIDTH`: saturating count of discarded beats.
- `in_data_i` in, `T`: upstream payload.
- `in_valid_i` in, 1: upstream valid.
- `in_ready_o` out, 1: upstream ready.
- `fifo_clear_o` out, 1: to the FIFO `src_clear_i`.
- `fifo_clear_pending_i` in, 1: from the FIFO `src_clear_pending_o`.
- `fifo_data_o` out, `T`: to the FIFO `src_data_i`.
- `fifo_valid_o` out, 1: to the FIFO `src_valid_i`.
- `fifo_ready_i` in, 1: from the FIFO `src_ready_o`.

## Operation

**Pipeline register**
- State is `valid_q` / `data_q`.
- In IDLE: `in_ready_o = !valid_q | fifo_ready_i`. This gives full throughput; the ready path is combinational.
- `fifo_valid_o = valid_q`; `fifo_data_o = data_q`.

**FSM states:** IDLE, DRAIN, CLEAR, WAIT_RISE, WAIT_FALL.
- **IDLE**
  - Normal forwarding.
  - `flush_req_i = 1` → DRAIN. A beat accepted on that same cycle is loaded into the register as usual.
- **DRAIN** (exactly 1 cycle)
  - `in_ready_o = 0`; `fifo_valid_o = valid_q`.
  - If `valid_q & fifo_ready_i`, the beat is delivered.
  - Otherwise, if `valid_q`, the beat is discarded and `drop_count` increments.
  - `valid_q` clears → CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `fifo_clear_o = 1`; `fifo_valid_o = 0` → WAIT_RISE.
  - Timeout counter is zeroed.
- **WAIT_RISE**
  - Wait for `fifo_clear_pending_i = 1` → WAIT_FALL.
- **WAIT_FALL**
  - Wait for `fifo_clear_pending_i = 0` → IDLE. Assert `flush_done_o` in the first IDLE cycle.
- **Timeout** (WAIT_RISE and WAIT_FALL)
  - The counter increments each cycle in either state.
  - When it reaches `TIMEOUT_CYCLES-1` without a normal exit → IDLE. Assert `flush_timeout_o` in the first IDLE cycle.
  - A normal exit on the same cycle wins over the timeout.
- **Signals in all non-IDLE states:** `fifo_valid_o = 0` except in DRAIN; `fifo_clear_o = 0` except in CLEAR.
- **Rules:**
  - `flush_req_i` while busy is ignored and not queued.
  - `fifo_clear_pending_i` rising in IDLE (a remote clear) causes no state change. The register holds its beat and delivers it once the FIFO is ready again.
  - `drop_count` saturates at all-ones and never wraps.

## Timing

- **Reset values:**
  - Outputs: state IDLE, `valid_q = 0`, `in_ready_o = 1`, `fifo_valid_o = 0`, `fifo_clear_o = 0`, `flush_busy_o = 0`, `flush_done_o = 0`, `flush_timeout_o = 0`, `drop_count_o = 0`.
  - Internal: timeout counter 0.
- **Forwarding latency:** input to `fifo_valid_o` is 1 cycle.
- **Flush sequence**, with `flush_req_i` seen at cycle 0:
  - Cycle 1: DRAIN; `flush_busy_o = 1`.
  - Cycle 2: CLEAR; `fifo_clear_o = 1`.
  - Cycle 3 onward: WAIT_RISE.
  - If pending is seen low at cycle N in WAIT_FALL, `flush_done_o = 1` and `flush_busy_o = 0` at cycle N+1.
- **Registered outputs:** `flush_done_o`, `flush_timeout_o` and `drop_count_o` are registered. `flush_busy_o` is decoded from the state register.
- **Reset mid-sequence:** `rst_i` returns the block to IDLE at the next edge and forces `fifo_clear_o` low. Any clear already started inside the FIFO completes independently. No done or timeout pulse is issued.

## Configuration

- **Macro `CDC_CLEAR_SEQ_DISCARD_EN`**
  - **Defined:** in states DRAIN through WAIT_FALL, `in_ready_o = 1`. Every upstream beat accepted during this window is discarded and increments `drop_count`, so upstream never stalls during a flush.
  - **Undefined:** `in_ready_o = 0` in all non-IDLE states. Upstream stalls, and `drop_count` counts only DRAIN-stage discards.

## Test plan

- **Reset and streaming:** hold `rst_i` high for 2 cycles, then stream 16 beats 0x00–0x0F with `fifo_ready_i = 1`. Required: all outputs at reset values during reset; beats appear on `fifo_data_o` in order with 1-cycle latency and no bubbles.
- **Normal flush:** `flush_req_i` at cycle 0 with register empty; pending rises at cycle 5 and falls at cycle 12. Required: `fifo_clear_o` high only at cycle 2; `flush_done_o` at cycle 13; `drop_count_o = 0`.
- **DRAIN discard:** register holds 0xA5, `fifo_ready_i = 0`, `flush_req_i` pulsed. Required: 0xA5 is never handshaken; `drop_count_o = 1`. Repeat with `fifo_ready_i = 1`: 0xA5 is delivered in DRAIN; count unchanged.
- **Timeout:** `TIMEOUT_CYCLES = 8`, pending never rises. Required: `flush_timeout_o` pulses 8 cycles after entering WAIT_RISE; `flush_done_o` never asserts; return to IDLE.
- **Discard mode:** with `CDC_CLEAR_SEQ_DISCARD_EN` defined, drive `in_valid_i = 1` continuously through a 10-cycle WAIT window. Required: `in_ready_o = 1`, `fifo_valid_o = 0`, and `drop_count_o` equals the number of beats offered. Without the macro, `in_ready_o = 0` throughout the same window.
- **Mid-flush reset and saturation:** assert `rst_i` in WAIT_FALL. Required: IDLE next cycle with no pulses. Separately, with `DROP_CNT_WIDTH = 2`, discard 5 beats. Required: `drop_count_o` holds at 3.
